// File: rtl/pin_router_if.sv
// Configuration bus from the serial command block into pin_router: shadow byte
// writes, commit/abort strobes, and readback of the active routing registers.
interface pin_router_if #(
    parameter int N_OUT = 16,
    parameter int SEL_W = 2
);
    logic                     wr_en;
    logic                     wr_sel;
    logic [1:0]               wr_idx;
    logic [7:0]               wr_data;
    logic                     commit;
    logic                     abort;
    logic                     pending;
    logic [N_OUT*SEL_W-1:0]   map_out;
    logic [N_OUT-1:0]         mask_out;

    modport master (
        output wr_en, wr_sel, wr_idx, wr_data, commit, abort,
        input  pending, map_out, mask_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_idx, wr_data, commit, abort,
        output pending, map_out, mask_out
    );
endinterface

// File: rtl/pin_router.sv
// Pin routing stage: byte-written shadow map/mask committed atomically to active
// registers, synchronized inputs, and registered tri-state outputs.
module pin_router #(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 16,
    parameter int SEL_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pin_router_if.slave       bus,
    input  logic [N_IN-1:0]   input_pins,
    output tri   [N_OUT-1:0]  output_pins
);
    localparam int MAP_W      = N_OUT * SEL_W;
    localparam int MAP_BYTES  = (MAP_W + 7) / 8;
    localparam int MASK_BYTES = (N_OUT + 7) / 8;

    logic [MAP_W-1:0]          shadow_map;
    logic [MAP_W-1:0]          active_map;
    logic [MAP_W-1:0]          map_next;
    logic [MAP_BYTES*8-1:0]    map_pad;
    logic [N_OUT-1:0]          shadow_mask;
    logic [N_OUT-1:0]          active_mask;
    logic [N_OUT-1:0]          mask_next;
    logic [MASK_BYTES*8-1:0]   mask_pad;
    logic                      write_hit;
    logic                      pending_q;

    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [N_IN-1:0]           sync_in;
    logic [SEL_W-1:0]          field;
    logic [N_OUT-1:0]          routed;
    logic [N_OUT-1:0]          out_val;
    logic [N_OUT-1:0]          out_oe;

    // Shadow contents after this cycle's write; a byte index beyond the selected
    // shadow matches no lane, so the write is a no-op and write_hit stays low.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
        map_pad   = (MAP_BYTES*8)'(shadow_map);
        mask_pad  = (MASK_BYTES*8)'(shadow_mask);
        write_hit = 1'b0;
        if (bus.wr_en && bus.wr_sel) begin
            for (int k = 0; k < MASK_BYTES; k++) begin
                if (bus.wr_idx == 2'(k)) begin
                    mask_pad[k*8 +: 8] = bus.wr_data;
                    write_hit          = 1'b1;
                end
            end
        end else if (bus.wr_en) begin
            for (int k = 0; k < MAP_BYTES; k++) begin
                if (bus.wr_idx == 2'(k)) begin
                    map_pad[k*8 +: 8] = bus.wr_data;
                    write_hit         = 1'b1;
                end
            end
        end
        map_next  = map_pad[MAP_W-1:0];
        mask_next = mask_pad[N_OUT-1:0];
    end

    // Commit outranks abort; a write in the commit cycle is forwarded into active.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            shadow_map  <= '0;
            shadow_mask <= '0;
            active_map  <= '0;
            active_mask <= '0;
            pending_q   <= 1'b0;
        end else if (bus.commit) begin
            shadow_map  <= map_next;
            shadow_mask <= mask_next;
            active_map  <= map_next;
            active_mask <= mask_next;
            pending_q   <= 1'b0;
        end else if (bus.abort) begin
            shadow_map  <= active_map;
            shadow_mask <= active_mask;
            pending_q   <= 1'b0;
        end else if (write_hit) begin
            shadow_map  <= map_next;
            shadow_mask <= mask_next;
            pending_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= input_pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Selects with no corresponding input (only possible when N_IN < 2**SEL_W) drive 0.
    always_comb begin
        routed = '0;
        field  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            field = active_map[i*SEL_W +: SEL_W];
            if (int'(field) < N_IN) begin
                routed[i] = sync_in[field];
            end
        end
    end

    // Data and enable register together, so a commit reaches the pins in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val <= '0;
            out_oe  <= '0;
        end else begin
            out_val <= routed;
            out_oe  <= active_mask;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_pin
        assign output_pins[g] = out_oe[g] ? out_val[g] : 1'bz;
    end

    assign bus.pending  = pending_q;
    assign bus.map_out  = active_map;
    assign bus.mask_out = active_mask;
endmodule

// File: doc/pin_router.md
Name: pin_router

Overview:
Routing stage directly downstream of the serial command block. It holds the pin map and output-enable mask as byte-addressed shadow registers. On a commit strobe it copies both shadows into active registers in one atomic step, so a partially written map or mask never reaches the pins. It synchronizes the external inputs and drives each output pin from its mapped input, or holds it high-impedance.

Parameters:
N_IN, 4, number of input pins
N_OUT, 16, number of output pins
SEL_W, 2, map field width per output (log2 N_IN)
SYNC_STAGES, 2, input synchronizer depth (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
wr_en  input  1  one-cycle strobe: write wr_data into shadow byte
wr_sel  input  1  0 = pin map shadow, 1 = enable mask shadow
wr_idx  input  2  byte index within selected shadow (byte 0 = bits [7:0])
wr_data  input  8  byte to write
commit  input  1  one-cycle strobe: shadow -> active
abort  input  1  one-cycle strobe: active -> shadow (discard staged bytes)
pending  output  1  shadow differs from active by at least one uncommitted write
map_out  output  N_OUT*SEL_W  active pin map, for readback
mask_out  output  N_OUT  active enable mask, for readback
input_pins  input  N_IN  asynchronous external inputs
output_pins  output  N_OUT  routed outputs, tri-state

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-high.
- Reset values: shadow_map, shadow_mask, active_map, active_mask = 0; pending = 0; all synchronizer flops = 0; out_val = 0; out_oe = 0. All output_pins are Z the cycle after reset is sampled.
- Map layout: output i sources input active_map[i*SEL_W +: SEL_W]. Bits 31:0 map to 4 bytes at default parameters.
- Shadow writes: on wr_en, shadow byte [wr_idx*8 +: 8] of the selected shadow <= wr_data, and pending <= 1.
  - Mask accepts wr_idx 0..1; wr_idx 2..3 are ignored and leave pending unchanged.
  - Map accepts wr_idx 0..3.
  - Repeated writes to the same byte: last write wins.
- Commit:
  - active_map <= shadow_map and active_mask <= shadow_mask, both on the same edge; pending <= 0.
  - wr_en and commit in the same cycle: the write is forwarded, so the committed value includes the new byte and pending ends at 0.
  - commit with pending = 0 is legal and changes nothing.
- Abort: shadow <= active and pending <= 0. If wr_en arrives in the same cycle as abort, the write is dropped.
- commit and abort in the same cycle: commit wins, and abort is ignored.
- Readback: map_out and mask_out always show the active registers, never the shadows.
- Input path: input_pins passes through a SYNC_STAGES flop chain to give sync_in.
- Output registers, updated every cycle:
  - out_val[i] <= sync_in[active_map field i]
  - out_oe <= active_mask
  - output_pins[i] = out_oe[i] ? out_val[i] : Z
- Latency:
  - An input change sampled at edge k appears on enabled outputs after edge k+SYNC_STAGES (3 edges total at default depth).
  - A commit sampled at edge k changes data and enables together on edge k+1. There is no cycle with the new mask and the old map, or the reverse.
- Out-of-range map values cannot occur while N_IN = 2^SEL_W. If N_IN < 2^SEL_W, unmapped selects drive 0.
- Reset mid-sequence (shadow partly written, pending = 1): everything returns to reset values, and the staged bytes are lost.

Test Plan:
- Reset, then check idle state -> output_pins all Z; map_out = 0; mask_out = 0; pending = 0.
- Write mask bytes 0xFF, 0xFF and map bytes 0,0,0,0 with no commit -> mask_out = 0, pins still Z, pending = 1. Then commit -> the edge after commit gives mask_out = 0xFFFF and all pins = input_pins[0] = 0; pending = 0.
- Set input_pins = 4'b0001 -> output_pins go 0 -> 1 exactly 3 edges later, with no earlier change.
- With map active at 0x00000000, write only map byte 0 = 0x01, then commit -> pin 0 follows input 1 (0) and pins 1..15 stay 1. Check that pins change on the same edge and that no intermediate value appears.
- Write map byte 3 = 0xAA, then abort -> map_out unchanged; pending = 0; a later commit leaves map_out unchanged.
- Same-cycle events:
  - wr_en (mask byte 1 = 0x00) with commit -> mask_out = 0x00FF the next cycle.
  - commit with abort -> commit applied.
  - mask write with wr_idx = 2 -> ignored, pending unchanged.
